param_scan_decoder: RTL

//  Registered, parametrised N-to-2**N one-hot decoder. Generalises the 3-to-8 decoder.
//  Two operating modes:
//   - DIRECT: registered decode of sel.
//   - SCAN:   free-running, clock-divided index sweep across all outputs, with a

---
 rtl/param_scan_decoder_if.sv | 36 +++
 rtl/param_scan_decoder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/param_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// param_scan_decoder_if
// Groups the control inputs and decoded outputs of param_scan_decoder.
//   en     enable; 0 deasserts every output line
//   mode   0 = DIRECT decode, 1 = SCAN sweep
//   sel    DIRECT: index to decode; SCAN: start index on scan entry
//   d      registered one-hot output (2**N lines)
//   idx    registered current index
//   valid  registered; 1 when d carries a decoded line
//   wrap   one-cycle pulse when the scan index wraps to 0
// master: drives en/mode/sel (controller side)
// slave:  drives d/idx/valid/wrap (decoder side)
// ---------------------------------------------------------------------------
interface param_scan_decoder_if #(
    parameter int N = 3
);
    localparam int OUTS = 2 ** N;

    logic            en;
    logic            mode;
    logic [N-1:0]    sel;
    logic [OUTS-1:0] d;
    logic [N-1:0]    idx;
    logic            valid;
    logic            wrap;

    modport master (
        output en, mode, sel,
        input  d, idx, valid, wrap
    );

    modport slave (
        input  en, mode, sel,
        output d, idx, valid, wrap
    );
endinterface

// File: rtl/param_scan_decoder.sv
// ---------------------------------------------------------------------------
// param_scan_decoder
// Registered N-to-2**N one-hot decoder with a DIRECT mode (decode sel) and a
// SCAN mode (clock-divided sweep of every output line with a wrap strobe),
// aimed at multiplexed display digit / keypad row drive.
// Parameters:
//   N         select width (1..6); output width OUTS = 2**N
//   SCAN_DIV  clocks each index is held in SCAN mode (>= 1)
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    param_scan_decoder_if.slave (en, mode, sel in; d, idx, valid, wrap out)
// Configuration macro:
//   DECODER_ACTIVE_LOW_EN  when defined, d is active-low (idle lines = 1);
//                          idx, valid and wrap are unaffected.
// ---------------------------------------------------------------------------
module param_scan_decoder #(
    parameter int N        = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    param_scan_decoder_if.slave  bus
);
    localparam int OUTS = 2 ** N;
    localparam int DW   = $clog2(SCAN_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIV_ZERO = {DW{1'b0}};
    localparam logic [N-1:0]  IDX_ZERO = {N{1'b0}};

`ifdef DECODER_ACTIVE_LOW_EN
    // Idle pattern doubles as the XOR mask that applies output polarity.
    localparam logic [OUTS-1:0] D_IDLE = {OUTS{1'b1}};
`else
    localparam logic [OUTS-1:0] D_IDLE = {OUTS{1'b0}};
`endif

    // State is a registered copy of mode.
    typedef enum logic {
        S_DIRECT = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [OUTS-1:0] d_r, d_s;
    logic [N-1:0]    idx_r, idx_s;
    logic [DW-1:0]   div_r, div_s;
    logic            valid_r, valid_s;
    logic            wrap_r, wrap_s;

    function automatic logic [OUTS-1:0] onehot(input logic [N-1:0] i);
        logic [OUTS-1:0] v;
        for (int k = 0; k < OUTS; k++) begin
            v[k] = (i == N'(k));
        end
        return v;
    endfunction

    // Next-state and next-output logic for both modes.
    always_comb begin
        idx_s   = idx_r;
        div_s   = div_r;
        wrap_s  = 1'b0;
        valid_s = 1'b0;
        d_s     = D_IDLE;

        // Mode tracking is independent of en.
        if (bus.mode) begin
            state_s = S_SCAN;
        end else begin
            state_s = S_DIRECT;
        end

        if (bus.en) begin
            valid_s = 1'b1;
            case (state_r)
                S_SCAN: begin
                    if (bus.mode) begin
                        // Steady scan: advance index on the last divider count.
                        if (div_r == DIV_LAST) begin
                            div_s  = DIV_ZERO;
                            idx_s  = idx_r + N'(1);
                            wrap_s = &idx_r;
                        end else begin
                            div_s  = div_r + DW'(1);
                        end
                    end else begin
                        // Scan exit behaves as a DIRECT decode.
                        idx_s = bus.sel;
                        div_s = DIV_ZERO;
                    end
                end
                default: begin
                    // DIRECT decode; also scan entry, which starts from sel.
                    idx_s = bus.sel;
                    div_s = DIV_ZERO;
                end
            endcase
            // d follows the index chosen in this same edge.
            d_s = onehot(idx_s) ^ D_IDLE;
        end else begin
            // Paused: idx/divider hold so the scan resumes where it stopped.
            idx_s = idx_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_DIRECT;
            d_r     <= D_IDLE;
            idx_r   <= IDX_ZERO;
            div_r   <= DIV_ZERO;
            valid_r <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            d_r     <= d_s;
            idx_r   <= idx_s;
            div_r   <= div_s;
            valid_r <= valid_s;
            wrap_r  <= wrap_s;
        end
    end

    assign bus.d     = d_r;
    assign bus.idx   = idx_r;
    assign bus.valid = valid_r;
    assign bus.wrap  = wrap_r;

endmodule
